// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax row loader.
// Q8.8 element format (16-bit two's complement, 8 fraction bits), the
// most-negative padding constant, default geometry, and a population-count
// helper used to measure how many lanes of a beat carry real data.
package softmax_pkg;

  localparam int              Q_W           = 16;
  localparam int              Q_FRAC        = 8;
  localparam logic [Q_W-1:0]  Q_PAD         = 16'h8000;
  localparam int              N_DEFAULT     = 64;
  localparam int              LANES_DEFAULT = 4;

  // Number of set bits; lane masks are at most 32 lanes wide.
  function automatic int unsigned count_ones(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) begin
      c += int'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/softmax_row_loader_if.sv
// Beat-in / row-out bus of the softmax row loader.
//   in_valid/in_ready/in_data/in_keep/in_last : input beat stream
//   in_x_flat/valid_in/row_len                : assembled row to softmax
//   out_stall                                 : downstream back-pressure
// master = producer/consumer side (testbench), slave = the loader.
interface softmax_row_loader_if
  import softmax_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int LANES = LANES_DEFAULT
) ();

  localparam int LEN_W = $clog2(N + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*Q_W-1:0]  in_data;
  logic [LANES-1:0]      in_keep;
  logic                  in_last;
  logic [N*Q_W-1:0]      in_x_flat;
  logic                  valid_in;
  logic                  out_stall;
  logic [LEN_W-1:0]      row_len;

  modport master (
    output in_valid, in_data, in_keep, in_last, out_stall,
    input  in_ready, in_x_flat, valid_in, row_len
  );

  modport slave (
    input  in_valid, in_data, in_keep, in_last, out_stall,
    output in_ready, in_x_flat, valid_in, row_len
  );

endinterface

// File: rtl/softmax_row_buf.sv
// One row buffer of the ping-pong pair.
//   clk, rst   : clock, synchronous active-high reset (clears data too)
//   wr_en      : write one beat at lanes beat_idx*LANES+k
//   close      : row complete; pad everything past this beat, mark full,
//                latch len_in
//   rel        : row consumed downstream; clear full
//   beat_idx   : beat position within the row
//   lane_data  : LANES Q8.8 elements, lane_keep selects real vs PAD
//   row_flat   : buffer contents, element i at [16i +: 16]
//   full       : row held and waiting for release
//   row_len    : number of real elements in the held row
module softmax_row_buf
  import softmax_pkg::*;
#(
  parameter int             N     = N_DEFAULT,
  parameter int             LANES = LANES_DEFAULT,
  parameter logic [Q_W-1:0] PAD   = Q_PAD,
  parameter int             BEAT_W = 4,
  parameter int             LEN_W  = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 close,
  input  logic                 rel,
  input  logic [BEAT_W-1:0]    beat_idx,
  input  logic [LANES*Q_W-1:0] lane_data,
  input  logic [LANES-1:0]     lane_keep,
  input  logic [LEN_W-1:0]     len_in,
  output logic [N*Q_W-1:0]     row_flat,
  output logic                 full,
  output logic [LEN_W-1:0]     row_len
);

  logic [Q_W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
      full    <= 1'b0;
      row_len <= '0;
    end else begin
      if (wr_en) begin
        for (int k = 0; k < LANES; k++) begin
          mem[int'(beat_idx) * LANES + k] <= lane_keep[k] ? lane_data[k*Q_W +: Q_W] : PAD;
        end
      end
      if (close) begin
        // Early close: every element beyond the closing beat becomes PAD so
        // stale data from a previous row never leaks into softmax.
        for (int i = 0; i < N; i++) begin
          if (i >= (int'(beat_idx) + 1) * LANES) begin
            mem[i] <= PAD;
          end
        end
        full    <= 1'b1;
        row_len <= len_in;
      end else if (rel) begin
        full <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign row_flat[g*Q_W +: Q_W] = mem[g];
  end

endmodule

// File: rtl/softmax_row_loader.sv
// Assembles LANES-wide Q8.8 beats into N-element rows for a softmax unit,
// double-buffered so one row can be presented while the next is filled.
//   clk, rst : clock, synchronous active-high reset (priority over en)
//   en       : global enable; low freezes all state
//   bus      : softmax_row_loader_if slave (beat input, row output,
//              out_stall back-pressure, row_len)
module softmax_row_loader
  import softmax_pkg::*;
#(
  parameter int             N     = N_DEFAULT,
  parameter int             LANES = LANES_DEFAULT,
  parameter logic [Q_W-1:0] PAD   = Q_PAD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  softmax_row_loader_if.slave  bus
);

  localparam int BEATS  = N / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LEN_W  = $clog2(N + 1);

  logic              wr_sel;
  logic              rd_sel;
  logic [BEAT_W-1:0] beat_cnt;
  logic [LEN_W-1:0]  len_acc;
  logic [LEN_W-1:0]  len_next;
  logic [1:0]        full;
  logic [N*Q_W-1:0]  row_flat [2];
  logic [LEN_W-1:0]  row_len_b [2];
  logic              ready;
  logic              accept;
  logic              close;
  logic              release_row;

  // Ready depends only on registered state plus en/rst: no in->out path.
  assign ready       = en & ~rst & ~full[wr_sel];
  assign accept      = bus.in_valid & ready;
  assign close       = accept & (bus.in_last | (beat_cnt == BEAT_W'(BEATS - 1)));
  assign release_row = full[rd_sel] & ~bus.out_stall & en;
  assign len_next    = len_acc + LEN_W'(count_ones(32'(bus.in_keep)));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      beat_cnt <= '0;
      len_acc  <= '0;
    end else begin
      if (close) begin
        wr_sel   <= ~wr_sel;
        beat_cnt <= '0;
        len_acc  <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
        len_acc  <= len_next;
      end
      // Release targets the other buffer than close, so both may fire together.
      if (release_row) begin
        rd_sel <= ~rd_sel;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_buf
    softmax_row_buf #(
      .N      (N),
      .LANES  (LANES),
      .PAD    (PAD),
      .BEAT_W (BEAT_W),
      .LEN_W  (LEN_W)
    ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (accept & (wr_sel == 1'(b))),
      .close     (close & (wr_sel == 1'(b))),
      .rel       (release_row & (rd_sel == 1'(b))),
      .beat_idx  (beat_cnt),
      .lane_data (bus.in_data),
      .lane_keep (bus.in_keep),
      .len_in    (len_next),
      .row_flat  (row_flat[b]),
      .full      (full[b]),
      .row_len   (row_len_b[b])
    );
  end

  assign bus.in_ready  = ready;
  assign bus.valid_in  = full[rd_sel];
  assign bus.in_x_flat = row_flat[rd_sel];
  assign bus.row_len   = row_len_b[rd_sel];

endmodule

// File: tb/tb_softmax_row_loader.sv
module tb_softmax_row_loader;
  import softmax_pkg::*;

  logic clk;
  logic rst;
  logic en;
  int   checks;
  int   errors;

  softmax_row_loader_if #(.N(64), .LANES(4)) bus ();

  softmax_row_loader #(.N(64), .LANES(4), .PAD(16'h8000)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] elem(input int i);
    return bus.in_x_flat[16*i +: 16];
  endfunction

  function automatic logic [63:0] beat_data(input logic [15:0] base, input logic [15:0] stp, input int b);
    logic [63:0] d;
    for (int k = 0; k < 4; k++) begin
      d[16*k +: 16] = base + 16'(4*b + k) * stp;
    end
    return d;
  endfunction

  // Send beats first..first+count-1 of a row whose element i = base+i*stp.
  task automatic send_beats(input logic [15:0] base, input logic [15:0] stp, input int first,
                            input int count, input logic [3:0] last_keep, input logic do_last);
    int wait_cyc;
    for (int b = first; b < first + count; b++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = beat_data(base, stp, b);
      bus.in_last  = do_last && (b == first + count - 1);
      bus.in_keep  = bus.in_last ? last_keep : 4'hF;
      #1;
      wait_cyc = 0;
      while (!bus.in_ready && wait_cyc < 100) begin
        step();
        wait_cyc++;
      end
      if (wait_cyc >= 100) check("ready_timeout", 32'(bus.in_ready), 32'd1);
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic check_row(input string tag, input logic [15:0] base, input logic [15:0] stp, input int nreal);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("%s_e%0d", tag, i), 32'(elem(i)),
            32'((i < nreal) ? base + 16'(i) * stp : 16'h8000));
    end
  endtask

  initial begin
    int low_cnt;
    int pulses;
    int prev_pulse;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    en  = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_keep   = '0;
    bus.in_last   = 1'b0;
    bus.out_stall = 1'b0;

    // Reset state
    step();
    check("ready_in_reset", 32'(bus.in_ready), 32'd0);
    check("rst_valid", 32'(bus.valid_in), 32'd0);
    check("rst_len", 32'(bus.row_len), 32'd0);
    check("rst_e0", 32'(elem(0)), 32'd0);
    check("rst_e63", 32'(elem(63)), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Full row, element i = i<<8
    bus.out_stall = 1'b1;
    send_beats(16'h0000, 16'h0100, 0, 15, 4'hF, 1'b0);
    check("full_pre_valid", 32'(bus.valid_in), 32'd0);
    send_beats(16'h0000, 16'h0100, 15, 1, 4'hF, 1'b1);
    check("full_valid", 32'(bus.valid_in), 32'd1);
    check("full_len", 32'(bus.row_len), 32'd64);
    check_row("full", 16'h0000, 16'h0100, 64);
    step();
    check("full_stall_hold", 32'(bus.valid_in), 32'd1);
    bus.out_stall = 1'b0;
    step();
    check("full_released", 32'(bus.valid_in), 32'd0);

    // Short row: last on beat 2 with keep=3
    bus.out_stall = 1'b1;
    send_beats(16'h1000, 16'h0001, 0, 3, 4'h3, 1'b1);
    check("short_valid", 32'(bus.valid_in), 32'd1);
    check("short_len", 32'(bus.row_len), 32'd10);
    check_row("short", 16'h1000, 16'h0001, 10);
    bus.out_stall = 1'b0;
    step();
    check("short_released", 32'(bus.valid_in), 32'd0);

    // Back-pressure: two rows fill both buffers, third row blocked
    bus.out_stall = 1'b1;
    send_beats(16'h2000, 16'h0001, 0, 1, 4'hF, 1'b1);
    send_beats(16'h3000, 16'h0001, 0, 2, 4'hF, 1'b1);
    check("bp_ready_low", 32'(bus.in_ready), 32'd0);
    check("bp_valid", 32'(bus.valid_in), 32'd1);
    check("bp_len_a", 32'(bus.row_len), 32'd4);
    bus.in_valid = 1'b1;
    bus.in_data  = beat_data(16'h4000, 16'h0001, 0);
    bus.in_keep  = 4'hF;
    bus.in_last  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_blocked", 32'(bus.in_ready), 32'd0);
      check("bp_hold_a", 32'(elem(0)), 32'h2000);
    end
    bus.in_valid  = 1'b0;
    bus.out_stall = 1'b0;
    step();
    check("bp_b_valid", 32'(bus.valid_in), 32'd1);
    check("bp_b_len", 32'(bus.row_len), 32'd8);
    check("bp_b_e0", 32'(elem(0)), 32'h3000);
    check("bp_ready_back", 32'(bus.in_ready), 32'd1);
    step();
    check("bp_drained", 32'(bus.valid_in), 32'd0);
    send_beats(16'h4000, 16'h0001, 0, 16, 4'hF, 1'b1);
    check("bp_c_valid", 32'(bus.valid_in), 32'd1);
    check("bp_c_len", 32'(bus.row_len), 32'd64);
    check("bp_c_e0", 32'(elem(0)), 32'h4000);
    step();
    check("bp_c_released", 32'(bus.valid_in), 32'd0);

    // Streaming: three rows back to back at one beat per cycle
    low_cnt    = 0;
    pulses     = 0;
    prev_pulse = 0;
    bus.in_valid = 1'b1;
    bus.in_keep  = 4'hF;
    for (int cyc = 0; cyc < 48; cyc++) begin
      bus.in_data = beat_data(16'h5000, 16'h0001, cyc % 16);
      bus.in_last = ((cyc % 16) == 15);
      #1;
      if (!bus.in_ready) low_cnt++;
      step();
      if (bus.valid_in) begin
        check("stream_len", 32'(bus.row_len), 32'd64);
        if (pulses > 0) check("stream_gap", 32'(cyc - prev_pulse), 32'd16);
        prev_pulse = cyc;
        pulses++;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("stream_ready_low_cycles", 32'(low_cnt), 32'd0);
    check("stream_pulses", 32'(pulses), 32'd3);
    step();
    check("stream_drained", 32'(bus.valid_in), 32'd0);

    // Reset mid-row discards the partial row
    bus.out_stall = 1'b1;
    send_beats(16'h6000, 16'h0001, 0, 7, 4'hF, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid", 32'(bus.valid_in), 32'd0);
    check("midrst_e0", 32'(elem(0)), 32'd0);
    check("midrst_len", 32'(bus.row_len), 32'd0);
    send_beats(16'h7000, 16'h0001, 0, 10, 4'hF, 1'b0);
    check("midrst_no_early_close", 32'(bus.valid_in), 32'd0);
    send_beats(16'h7000, 16'h0001, 10, 6, 4'hF, 1'b1);
    check("midrst_row_valid", 32'(bus.valid_in), 32'd1);
    check("midrst_row_len", 32'(bus.row_len), 32'd64);
    check_row("midrst", 16'h7000, 16'h0001, 64);
    bus.out_stall = 1'b0;
    step();
    check("midrst_released", 32'(bus.valid_in), 32'd0);

    // en=0 for 5 cycles mid-row
    bus.out_stall = 1'b1;
    send_beats(16'h0900, 16'h0001, 0, 5, 4'hF, 1'b0);
    en = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.in_keep  = 4'hF;
    bus.in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("en_ready_low", 32'(bus.in_ready), 32'd0);
      step();
      check("en_valid_hold", 32'(bus.valid_in), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    en = 1'b1;
    send_beats(16'h0900, 16'h0001, 5, 11, 4'hF, 1'b1);
    check("en_row_valid", 32'(bus.valid_in), 32'd1);
    check("en_row_len", 32'(bus.row_len), 32'd64);
    check_row("en", 16'h0900, 16'h0001, 64);
    en = 1'b0;
    bus.out_stall = 1'b0;
    step();
    step();
    check("en_no_release", 32'(bus.valid_in), 32'd1);
    en = 1'b1;
    step();
    check("en_released", 32'(bus.valid_in), 32'd0);

    // Illegal: last with empty keep on beat 0 still closes with row_len 0
    bus.out_stall = 1'b1;
    send_beats(16'h0A00, 16'h0001, 0, 1, 4'h0, 1'b1);
    check("empty_valid", 32'(bus.valid_in), 32'd1);
    check("empty_len", 32'(bus.row_len), 32'd0);
    check("empty_e0", 32'(elem(0)), 32'h8000);
    bus.out_stall = 1'b0;
    step();
    check("empty_released", 32'(bus.valid_in), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/softmax_row_loader.md
SOFTMAX_ROW_LOADER -- requirements
Module: softmax_row_loader

Interface
REQ-001 SHALL have parameter N, default 64, meaning elements per softmax row.
REQ-002 SHALL have parameter LANES, default 4, meaning Q8.8 elements per input beat; N SHALL be a multiple of LANES.
REQ-003 SHALL have parameter PAD, default 16'h8000, meaning the fill value for unused elements (most-negative Q8.8).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en  input  1  global enable; low freezes all state.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_ready  output  1  loader accepts beat.
REQ-009 in_data  input  LANES*16  signed Q8.8 elements, lane k at [16k +: 16].
REQ-010 in_keep  input  LANES  per-lane valid mask, contiguous from lane 0.
REQ-011 in_last  input  1  final beat of current row.
REQ-012 in_x_flat  output  N*16  assembled row for softmax, element i at [16i +: 16].
REQ-013 valid_in  output  1  row on in_x_flat valid (drives softmax valid_in).
REQ-014 out_stall  input  1  downstream cannot take row this cycle.
REQ-015 row_len  output  7  count of real (non-PAD) elements in presented row, 1..N.

Function
REQ-016 SHALL hold two row buffers (ping-pong), each with a full flag; write pointer wr_sel, read pointer rd_sel.
REQ-017 in_ready SHALL equal en AND NOT full[wr_sel].
REQ-018 Beat accepted when in_valid AND in_ready; it SHALL be written to buffer wr_sel at lanes beat_cnt*LANES+k.
REQ-019 Lanes with in_keep[k]=0 SHALL be written as PAD; their count SHALL not add to the row length.
REQ-020 beat_cnt SHALL run 0..N/LANES-1; the row closes on an accepted beat with in_last=1 or beat_cnt=N/LANES-1.
REQ-021 On early close (in_last at beat_cnt<N/LANES-1), all remaining lanes of that buffer SHALL be set to PAD in the same cycle.
REQ-022 On close: full[wr_sel]<=1, wr_sel toggles, beat_cnt<=0, latched row length stored with buffer.
REQ-023 Latency: close accepted at edge t -> valid_in=1 at t+1 (registered, no combinational in->out path).
REQ-024 valid_in SHALL equal full[rd_sel]; in_x_flat and row_len SHALL reflect buffer rd_sel and stay stable while valid_in AND out_stall.
REQ-025 Row released when valid_in AND NOT out_stall AND en: full[rd_sel]<=0, rd_sel toggles.
REQ-026 Release and close in the same cycle SHALL both take effect (different buffers); sustained 1 beat/cycle with out_stall=0 SHALL never deassert in_ready.
REQ-027 Both buffers full -> in_ready=0 until a release; the released buffer is writable the cycle after.
REQ-028 in_last with in_keep all-zero on beat 0 is illegal; behaviour is unspecified but SHALL not hang (row closes with row_len=0).
REQ-029 en=0: no acceptance, no release, all registers hold; outputs keep last values.

Reset
REQ-030 rst=1 at an edge: full flags, wr_sel, rd_sel, beat_cnt, valid_in, row_len <= 0; buffers <= 0 (in_x_flat=0).
REQ-031 rst SHALL take priority over en and discard any partial row; in_ready=0 during reset cycle.

Structure
REQ-032 Shared package softmax_pkg SHALL hold Q8.8 width (16), frac bits (8), PAD constant, default N.
REQ-033 One sub-module natural: softmax_row_buf (one N*16 buffer with lane write, PAD fill, full flag, length register), instantiated twice.

Verification
REQ-034 Full row: 16 beats, keep=4'hF, data element i = i*16'h0100, last on beat 15 -> valid_in one cycle later, in_x_flat[16i+:16]=i<<8, row_len=64.
REQ-035 Short row: 3 beats, last on beat 2 with keep=4'h3 -> row_len=10, elements 10..63 = 16'h8000.
REQ-036 Back-pressure: out_stall=1, push two full rows -> in_ready low after second close, third row blocked; drop out_stall -> rows emerge in order, one per unstalled cycle.
REQ-037 Streaming: continuous rows at 1 beat/cycle, out_stall=0 -> in_ready never low, valid_in pulses every 16 cycles.
REQ-038 Reset mid-row: rst after 7 beats -> valid_in stays 0, next row starts at element 0 with correct contents.
REQ-039 en=0 for 5 cycles mid-row -> no state change, row completes identically after en returns.
